// File: rtl/ishift_seq.sv
// ishift_seq: FIFO-buffered command sequencer for the iterative shifter; define ISHIFT_SEQ_SAT_EN to bypass counts >= WIDTH
module ishift_seq #(
   parameter int WIDTH       = 16,
   parameter int FDEPTH_LOG2 = 2
) (
   input  logic                   clk,
   input  logic                   arst,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic [1:0]             cmd_fmt,
   input  logic [4:0]             cmd_cnt,
   input  logic [WIDTH-1:0]       cmd_a,
   output logic                   res_valid,
   input  logic                   res_ready,
   output logic [WIDTH-1:0]       res_y,
   output logic [FDEPTH_LOG2:0]   pending,
   output logic                   sh_go,
   output logic [1:0]             sh_fmt,
   output logic [4:0]             sh_cnt,
   output logic [WIDTH-1:0]       sh_a,
   input  logic                   sh_busy,
   input  logic [WIDTH-1:0]       sh_y
);
   localparam int DEPTH = 1 << FDEPTH_LOG2;
   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] LAUNCH = 3'd1;
   localparam logic [2:0] ARM    = 3'd2;
   localparam logic [2:0] WAIT   = 3'd3;
   localparam logic [2:0] DONE   = 3'd4;

   logic [1:0]             f_fmt [DEPTH];
   logic [4:0]             f_cnt [DEPTH];
   logic [WIDTH-1:0]       f_a   [DEPTH];
   logic [FDEPTH_LOG2-1:0] wr_ptr, rd_ptr;
   logic [FDEPTH_LOG2:0]   count;
   logic [2:0]             state;
   logic                   push, pop, sat;

   assign cmd_ready = count != (FDEPTH_LOG2+1)'(DEPTH);
   assign push      = cmd_valid & cmd_ready;
   assign pop       = state == IDLE && count != '0 && !res_valid;
   assign sh_go     = state == LAUNCH;
   assign pending   = count + (FDEPTH_LOG2+1)'(state != IDLE);
`ifdef ISHIFT_SEQ_SAT_EN
   assign sat = pop && 32'(f_cnt[rd_ptr]) >= WIDTH;
`else
   assign sat = 1'b0;
`endif

   // command storage; entries need no reset since count gates every read
   always_ff @(posedge clk) begin
      if (push) begin
         f_fmt[wr_ptr] <= cmd_fmt;
         f_cnt[wr_ptr] <= cmd_cnt;
         f_a[wr_ptr]   <= cmd_a;
      end
   end

   // FIFO bookkeeping, launch FSM and held result register
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         state     <= IDLE;
         res_valid <= 1'b0;
         res_y     <= '0;
         sh_fmt    <= '0;
         sh_cnt    <= '0;
         sh_a      <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + FDEPTH_LOG2'(1);
         if (pop) rd_ptr <= rd_ptr + FDEPTH_LOG2'(1);
         count <= count + (FDEPTH_LOG2+1)'(push) - (FDEPTH_LOG2+1)'(pop);
         case (state)
            IDLE: begin
               if (sat) begin
                  res_y     <= f_fmt[rd_ptr] == 2'd2 ? {WIDTH{f_a[rd_ptr][WIDTH-1]}} : '0;
                  res_valid <= 1'b1;
                  state     <= DONE;
               end else if (pop) begin
                  sh_fmt <= f_fmt[rd_ptr];
                  sh_cnt <= f_cnt[rd_ptr];
                  sh_a   <= f_a[rd_ptr];
                  state  <= LAUNCH;
               end
            end
            LAUNCH: state <= ARM;
            ARM:    state <= WAIT;
            WAIT: begin
               if (!sh_busy) begin
                  res_y     <= sh_y;
                  res_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
